// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial ADD/SUB/INC/DEC sequencer around one full-adder cell
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operand shift registers, consumed LSB first
  logic [WIDTH-1:0] sa, sb;
  // Upper WIDTH-1 bits of the partial result; the newest sum bit enters at the top
  logic [WIDTH-2:0] w;
  logic             c;
  logic             nz;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic             s;
  logic             co;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] b_eff;
  logic             c_init;

  // Adder cell, step decode and operand conditioning
  always_comb begin
    accept = (state == S_IDLE) && start;
    last   = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
    s      = sa[0] ^ sb[0] ^ c;
    co     = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    word   = {s, w};
    b_eff  = b;
    c_init = 1'b0;
    case (op)
      OP_ADD: begin b_eff = b;             c_init = 1'b0; end
      OP_SUB: begin b_eff = ~b;            c_init = 1'b1; end
      OP_INC: begin b_eff = '0;            c_init = 1'b1; end
      OP_DEC: begin b_eff = '1;            c_init = 1'b0; end
      default: begin b_eff = b;            c_init = 1'b0; end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (last)  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand load on accept, one bit-step per cycle while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      w   <= '0;
      c   <= 1'b0;
      nz  <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b_eff;
      c   <= c_init;
      nz  <= 1'b0;
      cnt <= '0;
    end else if (state == S_RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      w   <= word[WIDTH-1:1];
      c   <= co;
      nz  <= nz | s;
      cnt <= cnt + CW'(1);
    end
  end

  // Result and flags change only on the final bit-step and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (last) begin
      result <= word;
      cout   <= co;
      ovf    <= c ^ co;
      zero   <= ~(nz | s);
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - scoreboard bench for serial_addsub_ctrl at WIDTH 8 and 4
module tb_serial_addsub_ctrl;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] INC = 2'b10;
  localparam logic [1:0] DEC = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic       start8;
  logic [1:0] op8;
  logic [7:0] a8, b8;
  logic       busy8, done8;
  logic [7:0] result8;
  logic       cout8, ovf8, zero8;

  logic       start4;
  logic [1:0] op4;
  logic [3:0] a4, b4;
  logic       busy4, done4;
  logic [3:0] result4;
  logic       cout4, ovf4, zero4;

  int n_vec = 0;
  int n_bad = 0;

  // Expected entries: {cout, ovf, zero, result (zero-extended to 8 bits)}
  logic [10:0] q8[$];
  logic [10:0] q4[$];
  logic [10:0] e8, e4;

  serial_addsub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  serial_addsub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4), .zero(zero4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 8-bit instance: every done pulse consumes one expected entry
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL done8_unexpected: got done with result 0x%0h, want no done", result8);
      end else begin
        e8 = q8.pop_front();
        chk("result8", {24'd0, result8}, {24'd0, e8[7:0]});
        chk("flags8_cout_ovf_zero", {29'd0, cout8, ovf8, zero8}, {29'd0, e8[10:8]});
      end
    end
  end

  // Monitor for the 4-bit instance
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done4 === 1'b1) begin
      if (q4.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL done4_unexpected: got done with result 0x%0h, want no done", result4);
      end else begin
        e4 = q4.pop_front();
        chk("result4", {28'd0, result4}, {24'd0, e4[7:0]});
        chk("flags4_cout_ovf_zero", {29'd0, cout4, ovf4, zero4}, {29'd0, e4[10:8]});
      end
    end
  end

  // One 8-bit operation with busy/done timing checked at every cycle through E9
  task automatic issue8(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] er, input logic ec, input logic eo, input logic ez);
    @(negedge clk);
    op8 = o; a8 = av; b8 = bv; start8 = 1'b1;
    q8.push_back({ec, eo, ez, er});
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom);
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("busy8_k%0d", k), {31'd0, busy8}, (k <= 8) ? 32'd1 : 32'd0);
      chk($sformatf("done8_k%0d", k), {31'd0, done8}, (k == 8) ? 32'd1 : 32'd0);
    end
  endtask

  // One 4-bit operation with busy/done timing checked through E5
  task automatic issue4(input logic [1:0] o, input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] er, input logic ec, input logic eo, input logic ez);
    @(negedge clk);
    op4 = o; a4 = av; b4 = bv; start4 = 1'b1;
    q4.push_back({ec, eo, ez, 4'h0, er});
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("busy4_k%0d", k), {31'd0, busy4}, (k <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("done4_k%0d", k), {31'd0, done4}, (k == 4) ? 32'd1 : 32'd0);
    end
  endtask

  int ndone;

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; op8 = ADD; a8 = 8'h00; b8 = 8'h00;
    start4 = 1'b0; op4 = ADD; a4 = 4'h0; b4 = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk("rst_result8", {24'd0, result8}, 32'd0);
    chk("rst_flags8", {29'd0, cout8, ovf8, zero8}, 32'd0);
    chk("rst_result4", {28'd0, result4}, 32'd0);
    chk("rst_flags4", {28'd0, busy4, cout4, ovf4, zero4}, 32'd0);
    rst_n = 1'b1;

    issue8(ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    issue8(SUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0);
    issue8(SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
    issue8(SUB, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 1'b1);
    issue8(INC, 8'hFF, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b1);
    issue8(DEC, 8'h00, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0);
    issue8(DEC, 8'h80, 8'hA5, 8'h7F, 1'b1, 1'b1, 1'b0);

    // start held high with operands churning: only E0 and E10 operands matter
    @(negedge clk);
    op8 = ADD; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    q8.push_back({1'b0, 1'b0, 1'b0, 8'h46});
    ndone = 0;
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      if (done8) ndone++;
      if (k <= 8) begin
        a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom);
      end else if (k == 9) begin
        op8 = ADD; a8 = 8'h81; b8 = 8'h81;
        q8.push_back({1'b1, 1'b1, 1'b0, 8'h02});
        chk("hold_busy_k9", {31'd0, busy8}, 32'd0);
      end else if (k == 10) begin
        start8 = 1'b0;
        chk("hold_busy_k10", {31'd0, busy8}, 32'd1);
      end
      if (k >= 8) chk($sformatf("hold_result_k%0d", k), {24'd0, result8}, 32'h46);
    end
    chk("hold_single_done", ndone, 32'd1);
    @(negedge clk);
    chk("hold_done_k18", {31'd0, done8}, 32'd1);
    @(negedge clk);
    chk("hold_done_k19", {31'd0, done8}, 32'd0);

    // Reset in flight between E4 and E5: no done may follow
    @(negedge clk);
    op8 = ADD; a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_result", {24'd0, result8}, 32'd0);
    chk("abort_flags", {29'd0, cout8, ovf8, zero8}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle_k%0d", k), {30'd0, busy8, done8}, 32'd0);
    end
    issue8(ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);

    issue4(ADD, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0);
    issue4(ADD, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("q8_drained", q8.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
